// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single data-memory port.
// Master 0 is the CPU load/store path, master 1 is the debug/program-loader port.
// Grant and strobes are combinational; load data is registered for one cycle.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              cpu_stall,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr_enable,
  output logic              mem_rd_enable,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam logic [7:0] MaxLockCnt = 8'(MAX_LOCK);

  logic              last_gnt_q, last_gnt_d;
  logic [7:0]        lock_cnt_q, lock_cnt_d;
  logic              rsel_q, rsel_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic locked;
  logic lock_full;
  logic gnt0;
  logic gnt1;

  // Pick at most one winner; nothing is granted while reset is held.
  always_comb begin
    locked    = last_gnt_q & m1_lock;
    lock_full = (lock_cnt_q == MaxLockCnt);
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (rst) begin
      if (m0_req && m1_req) begin
        if (locked) begin
          // A saturated lock forces one CPU access through.
          gnt0 = lock_full;
          gnt1 = ~lock_full;
        end else begin
          gnt0 = last_gnt_q;
          gnt1 = ~last_gnt_q;
        end
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
  end

  // Route the winner onto the memory port; idle port is driven to zero.
  always_comb begin
    mem_addr      = '0;
    mem_wr_data   = '0;
    mem_wr_enable = 1'b0;
    mem_rd_enable = 1'b0;
    if (gnt0) begin
      mem_addr      = m0_addr;
      mem_wr_data   = m0_wdata;
      mem_wr_enable = m0_we;
      mem_rd_enable = ~m0_we;
    end else if (gnt1) begin
      mem_addr      = m1_addr;
      mem_wr_data   = m1_wdata;
      mem_wr_enable = m1_we;
      mem_rd_enable = ~m1_we;
    end
  end

  // Next-state: round-robin history, lock counter and read-return register.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt0) begin
      last_gnt_d = 1'b0;
    end else if (gnt1) begin
      last_gnt_d = 1'b1;
    end

    lock_cnt_d = lock_cnt_q;
    if (gnt0 || !m1_lock) begin
      lock_cnt_d = '0;
    end else if (gnt1 && !lock_full) begin
      lock_cnt_d = lock_cnt_q + 8'd1;
    end

    rvalid_d = mem_rd_enable;
    rsel_d   = rsel_q;
    rdata_d  = rdata_q;
    if (mem_rd_enable) begin
      rsel_d  = gnt1;
      rdata_d = mem_rd_data;
    end
  end

  // State registers; last_gnt resets to 1 so master 0 wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt_q <= 1'b1;
      lock_cnt_q <= '0;
      rsel_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
      rsel_q     <= rsel_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign cpu_stall = m0_req & ~gnt0;
  assign m0_rvalid = rvalid_q & ~rsel_q;
  assign m1_rvalid = rvalid_q & rsel_q;
  assign m0_rdata  = rdata_q;
  assign m1_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed transactions, expected grants and
// read returns queued by the stimulus, checked by an independent monitor.
module tb_dmem_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        lock;
  } req_t;

  typedef struct packed {
    logic        m1;
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
  } gnt_t;

  typedef struct packed {
    logic        m1;
    logic [63:0] data;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0;
  logic [63:0] m0_wdata = '0;
  logic        m0_gnt, m0_rvalid, cpu_stall;
  logic [63:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [31:0] m1_addr = '0;
  logic [63:0] m1_wdata = '0;
  logic        m1_gnt, m1_rvalid;
  logic [63:0] m1_rdata;
  logic [31:0] mem_addr;
  logic [63:0] mem_wr_data;
  logic        mem_wr_enable, mem_rd_enable;
  logic [63:0] mem_rd_data;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int stall_cnt = 0;
  int rv1_cnt = 0;

  req_t m0_q[$];
  req_t m1_q[$];
  gnt_t gnt_q[$];
  rd_t  rd_q[$];
  int   ld_cyc[$];

  // Memory model: unwritten words read back as C0DEC0DEC0DE00 followed by the address low byte.
  logic [63:0] mem [64];
  logic [63:0] wr_seen = '0;
  assign mem_rd_data = wr_seen[mem_addr[8:3]] ? mem[mem_addr[8:3]]
                                              : {56'hC0DEC0DEC0DE00, mem_addr[7:0]};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr_enable) begin
      mem[mem_addr[8:3]]     <= mem_wr_data;
      wr_seen[mem_addr[8:3]] <= 1'b1;
    end
  end

  dmem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (64),
    .MAX_LOCK(4)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .m0_req       (m0_req),
    .m0_we        (m0_we),
    .m0_addr      (m0_addr),
    .m0_wdata     (m0_wdata),
    .m0_gnt       (m0_gnt),
    .m0_rvalid    (m0_rvalid),
    .m0_rdata     (m0_rdata),
    .cpu_stall    (cpu_stall),
    .m1_req       (m1_req),
    .m1_we        (m1_we),
    .m1_addr      (m1_addr),
    .m1_wdata     (m1_wdata),
    .m1_lock      (m1_lock),
    .m1_gnt       (m1_gnt),
    .m1_rvalid    (m1_rvalid),
    .m1_rdata     (m1_rdata),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_enable(mem_wr_enable),
    .mem_rd_enable(mem_rd_enable),
    .mem_rd_data  (mem_rd_data)
  );

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant or read return.
  always @(negedge clk) begin
    gnt_t e;
    rd_t  r;
    int   lc;
    if (cpu_stall) stall_cnt++;
    if (m1_rvalid) rv1_cnt++;
    chk("exclusive", {m0_gnt & m1_gnt, mem_wr_enable & mem_rd_enable}, '0);
    if (!rst) ld_cyc.delete();
    if (m0_gnt || m1_gnt) begin
      if (gnt_q.size() == 0) begin
        chk("unexpected_gnt", {m0_gnt, m1_gnt}, '0);
      end else begin
        e = gnt_q.pop_front();
        chk("gnt", {m1_gnt, m0_gnt, mem_wr_enable, mem_rd_enable, mem_addr, mem_wr_data},
            {e.m1, ~e.m1, e.we, ~e.we, e.addr, e.wdata});
        if (mem_rd_enable) ld_cyc.push_back(cyc);
      end
    end
    if (m0_rvalid || m1_rvalid) begin
      if (rd_q.size() == 0) begin
        chk("unexpected_rvalid", {m0_rvalid, m1_rvalid}, '0);
      end else begin
        r  = rd_q.pop_front();
        lc = (ld_cyc.size() != 0) ? ld_cyc.pop_front() : -10;
        chk("rvalid_latency", 192'(cyc), 192'(lc + 1));
        chk("rdata", {m1_rvalid, m0_rvalid, m0_rdata, m1_rdata}, {r.m1, ~r.m1, r.data, r.data});
      end
    end
  end

  task automatic apply();
    req_t r0, r1;
    r0 = '0;
    r1 = '0;
    if (m0_q.size() != 0) r0 = m0_q[0];
    if (m1_q.size() != 0) r1 = m1_q[0];
    m0_req   = (m0_q.size() != 0);
    m0_we    = r0.we;
    m0_addr  = r0.addr;
    m0_wdata = r0.wdata;
    m1_req   = (m1_q.size() != 0);
    m1_we    = r1.we;
    m1_addr  = r1.addr;
    m1_wdata = r1.wdata;
    m1_lock  = r1.lock;
  endtask

  // Level-held masters: a request is retired only after its grant is seen.
  task automatic step();
    logic g0, g1;
    @(negedge clk);
    g0 = m0_gnt;
    g1 = m1_gnt;
    @(posedge clk);
    #1;
    if (g0 && m0_q.size() != 0) m0_q.delete(0);
    if (g1 && m1_q.size() != 0) m1_q.delete(0);
    apply();
  endtask

  task automatic run(input string name, input int exp_cycles);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    apply();
    while ((m0_q.size() != 0 || m1_q.size() != 0) && n < 100) begin
      step();
      n++;
    end
    chk(name, 192'(n), 192'(exp_cycles));
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    m0_q.delete();
    m1_q.delete();
    apply();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic req_t mk(input logic we, input logic [31:0] a, input logic [63:0] d,
                              input logic lk);
    req_t r;
    r.we = we; r.addr = a; r.wdata = d; r.lock = lk;
    return r;
  endfunction

  function automatic gnt_t eg(input logic m, input logic we, input logic [31:0] a,
                              input logic [63:0] d);
    gnt_t g;
    g.m1 = m; g.we = we; g.addr = a; g.wdata = d;
    return g;
  endfunction

  function automatic rd_t er(input logic m, input logic [63:0] d);
    rd_t r;
    r.m1 = m; r.data = d;
    return r;
  endfunction

  initial begin
    int s0, rv0;

    // Reset with m1 pushing a store: nothing may reach memory.
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h10; m1_wdata = 64'h55;
    repeat (2) @(negedge clk);
    chk("reset_strobes", {mem_wr_enable, mem_rd_enable, m1_gnt, m0_gnt}, '0);
    chk("reset_rvalid_stall", {m0_rvalid, m1_rvalid, cpu_stall}, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    apply();
    @(negedge clk);
    chk("idle_after_reset", {mem_wr_enable, mem_rd_enable, m0_rvalid, m1_rvalid, cpu_stall}, '0);

    // Single master: store then load back.
    s0 = stall_cnt;
    m0_q.push_back(mk(1'b1, 32'h10, 64'hDEAD_BEEF, 1'b0));
    m0_q.push_back(mk(1'b0, 32'h10, 64'h0, 1'b0));
    gnt_q.push_back(eg(1'b0, 1'b1, 32'h10, 64'hDEAD_BEEF));
    gnt_q.push_back(eg(1'b0, 1'b0, 32'h10, 64'h0));
    rd_q.push_back(er(1'b0, 64'h0000_0000_DEAD_BEEF));
    run("single_cycles", 2);
    chk("single_stall", 192'(stall_cnt - s0), 192'(0));

    // Unlocked contention: strict alternation starting with m0.
    do_reset();
    s0 = stall_cnt;
    for (int i = 0; i < 3; i++) begin
      m0_q.push_back(mk(1'b0, 32'h40 + 32'(8 * i), 64'h0, 1'b0));
      m1_q.push_back(mk(1'b0, 32'h80 + 32'(8 * i), 64'h0, 1'b0));
    end
    gnt_q.push_back(eg(1'b0, 1'b0, 32'h40, 64'h0));
    gnt_q.push_back(eg(1'b1, 1'b0, 32'h80, 64'h0));
    gnt_q.push_back(eg(1'b0, 1'b0, 32'h48, 64'h0));
    gnt_q.push_back(eg(1'b1, 1'b0, 32'h88, 64'h0));
    gnt_q.push_back(eg(1'b0, 1'b0, 32'h50, 64'h0));
    gnt_q.push_back(eg(1'b1, 1'b0, 32'h90, 64'h0));
    rd_q.push_back(er(1'b0, 64'hC0DEC0DEC0DE0040));
    rd_q.push_back(er(1'b1, 64'hC0DEC0DEC0DE0080));
    rd_q.push_back(er(1'b0, 64'hC0DEC0DEC0DE0048));
    rd_q.push_back(er(1'b1, 64'hC0DEC0DEC0DE0088));
    rd_q.push_back(er(1'b0, 64'hC0DEC0DEC0DE0050));
    rd_q.push_back(er(1'b1, 64'hC0DEC0DEC0DE0090));
    run("contend_cycles", 6);
    chk("contend_stall", 192'(stall_cnt - s0), 192'(2));

    // Locked m1 burst: four m1 grants, one forced m0 grant, then m1 resumes.
    do_reset();
    s0 = stall_cnt;
    m0_q.push_back(mk(1'b0, 32'h10, 64'h0, 1'b0));
    for (int i = 0; i < 6; i++) m1_q.push_back(mk(1'b1, 32'h100 + 32'(8 * i), 64'hB0 + 64'(i), 1'b1));
    for (int i = 0; i < 4; i++) gnt_q.push_back(eg(1'b1, 1'b1, 32'h100 + 32'(8 * i), 64'hB0 + 64'(i)));
    gnt_q.push_back(eg(1'b0, 1'b0, 32'h10, 64'h0));
    gnt_q.push_back(eg(1'b1, 1'b1, 32'h120, 64'hB4));
    gnt_q.push_back(eg(1'b1, 1'b1, 32'h128, 64'hB5));
    rd_q.push_back(er(1'b0, 64'h0000_0000_DEAD_BEEF));
    run("lock_cycles", 7);
    chk("lock_stall", 192'(stall_cnt - s0), 192'(4));

    // Lock dropped mid-burst: m0 wins next, and a fresh burst gets a full four grants.
    do_reset();
    s0 = stall_cnt;
    m0_q.push_back(mk(1'b0, 32'h10, 64'h0, 1'b0));
    m0_q.push_back(mk(1'b0, 32'h40, 64'h0, 1'b0));
    for (int i = 0; i < 8; i++)
      m1_q.push_back(mk(1'b1, 32'h180 + 32'(8 * i), 64'hA0 + 64'(i), (i == 2) ? 1'b0 : 1'b1));
    gnt_q.push_back(eg(1'b1, 1'b1, 32'h180, 64'hA0));
    gnt_q.push_back(eg(1'b1, 1'b1, 32'h188, 64'hA1));
    gnt_q.push_back(eg(1'b0, 1'b0, 32'h10, 64'h0));
    for (int i = 2; i < 7; i++) gnt_q.push_back(eg(1'b1, 1'b1, 32'h180 + 32'(8 * i), 64'hA0 + 64'(i)));
    gnt_q.push_back(eg(1'b0, 1'b0, 32'h40, 64'h0));
    gnt_q.push_back(eg(1'b1, 1'b1, 32'h1B8, 64'hA7));
    rd_q.push_back(er(1'b0, 64'h0000_0000_DEAD_BEEF));
    rd_q.push_back(er(1'b0, 64'hC0DEC0DEC0DE0040));
    run("release_cycles", 10);
    chk("release_stall", 192'(stall_cnt - s0), 192'(7));

    // Reset in the cycle after an m1 load grant drops the pending return.
    do_reset();
    rv0 = rv1_cnt;
    m1_q.push_back(mk(1'b0, 32'h80, 64'h0, 1'b0));
    gnt_q.push_back(eg(1'b1, 1'b0, 32'h80, 64'h0));
    @(posedge clk);
    #1;
    apply();
    @(posedge clk);
    #1;
    rst = 1'b0;
    m1_q.delete();
    apply();
    @(negedge clk);
    chk("reset_drop_rvalid", {m0_rvalid, m1_rvalid}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    m0_q.push_back(mk(1'b0, 32'h48, 64'h0, 1'b0));
    m1_q.push_back(mk(1'b0, 32'h88, 64'h0, 1'b0));
    gnt_q.push_back(eg(1'b0, 1'b0, 32'h48, 64'h0));
    gnt_q.push_back(eg(1'b1, 1'b0, 32'h88, 64'h0));
    rd_q.push_back(er(1'b0, 64'hC0DEC0DEC0DE0048));
    rd_q.push_back(er(1'b1, 64'hC0DEC0DEC0DE0088));
    run("post_reset_cycles", 2);
    chk("m1_rvalid_count", 192'(rv1_cnt - rv0), 192'(1));

    chk("gnt_queue_drained", 192'(gnt_q.size()), 192'(0));
    chk("rd_queue_drained", 192'(rd_q.size()), 192'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard stop in case a wait never resolves.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter that shares the single data-memory port (`data_mem`) between the CPU load/store path (master 0) and a debug/program-loader port (master 1). It sits between the CPU datapath and `data_mem`. It chooses one access per cycle, drives the memory strobes and registers read data for the winner. It also produces a stall for the CPU so the single-cycle core freezes its PC while it waits for a grant.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 64: data width.
- `MAX_LOCK`, 8: maximum number of consecutive master-1 grants under lock before one master-0 access is forced; legal range 1..255.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `m0_req`  in  1  CPU requests an access this cycle (`mem_read | mem_write`).
- `m0_we`  in  1  1 = store, 0 = load.
- `m0_addr`  in  ADDR_W  CPU byte address (`alu_result`).
- `m0_wdata`  in  DATA_W  CPU store data.
- `m0_gnt`  out  1  access performed this cycle (combinational).
- `m0_rvalid`  out  1  registered load data valid.
- `m0_rdata`  out  DATA_W  registered load data.
- `cpu_stall`  out  1  `m0_req & ~m0_gnt`; gates PC and register-file write.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_gnt`, `m1_rvalid`, `m1_rdata`: same meanings as the m0 signals, for the debug/loader master.
- `m1_lock`  in  1  keep master 1 granted on following cycles (burst load).
- `mem_addr`  out  ADDR_W  to `data_mem` `addr`.
- `mem_wr_data`  out  DATA_W  to `wr_data`.
- `mem_wr_enable`  out  1  to `wr_enable`.
- `mem_rd_enable`  out  1  to `rd_enable`.
- `mem_rd_data`  in  DATA_W  from `rd_data` (combinational read).

## Operation
- State:
  - `last_gnt` (1 bit, the last master granted).
  - `lock_cnt` (8 bits).
  - `rsel` (1 bit, owner of the pending read).
  - `rvalid_q`, `rdata_q`.
- Arbitration, evaluated combinationally each cycle:
  - Only one requester: it wins.
  - Both requesting, master 1 locked: master 1 wins, unless `lock_cnt == MAX_LOCK`, in which case master 0 wins.
  - Both requesting, no lock: round-robin; the master opposite `last_gnt` wins.
  - Locked means `last_gnt==1 & m1_lock`.
- Winner drives the memory:
  - `mem_addr` and `mem_wr_data` come from the winner.
  - `mem_wr_enable = we`.
  - `mem_rd_enable = ~we`.
- No grant: both enables 0, `mem_addr`/`mem_wr_data` = 0.
- `lock_cnt`:
  - Increments, saturating at `MAX_LOCK`, on a master-1 grant while `m1_lock=1`.
  - Clears on any master-0 grant and on any cycle with `m1_lock=0`.
- Reads:
  - On a granted load, the next edge captures `rdata_q <= mem_rd_data` and `rsel <= winner`, and sets `rvalid_q` for one cycle.
  - `mX_rvalid = rvalid_q & (rsel==X)`.
  - `mX_rdata = rdata_q` for both masters; only the master whose `rvalid` is set may use it.
- Writes complete in their grant cycle; no write response is generated.
- Both enables are never 1 in the same cycle.
- At most one grant per cycle.

## Timing
- Reset (`rst`=0, asynchronous):
  - `last_gnt`=1, so master 0 wins the first contention.
  - `lock_cnt`=0, `rvalid_q`=0, `rdata_q`=0, `rsel`=0.
  - All `rvalid` outputs are 0 while in reset.
- Grant and memory strobes: 0-cycle latency, in the same cycle as the request.
- Read data: 1-cycle latency; `rvalid` is high in cycle N+1 for a load granted in cycle N.
- Back-to-back loads from either master: one per cycle, with `rvalid` stream-aligned.
- Requests are level-held: a master keeps `req`, `addr`, `we` and `wdata` stable until it sees `gnt`; the arbiter keeps no request queue.
- `cpu_stall` is combinational and valid in the same cycle as `m0_req`.
- Maximum CPU wait:
  - With m1 locked: `MAX_LOCK` cycles.
  - Unlocked: 1 cycle.
- Reset asserted mid-read: the pending `rvalid` is dropped, never delivered.

## Test plan
- Reset then idle:
  - Drive `rst`=0 with any inputs -> all enables 0, `rvalid`=0, `cpu_stall`=0 when `m0_req`=0.
  - Release reset -> still idle.
- Single master: m0 store of 0xDEAD_BEEF to 0x10, then m0 load from 0x10:
  - Store -> `m0_gnt`=1 in the same cycle.
  - Load -> `m0_rvalid`=1 with `m0_rdata`=0xDEAD_BEEF one cycle after its grant.
  - `cpu_stall`=0 throughout.
- Contention, unlocked: both request loads continuously for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1 starting with m0 after reset, and each `rvalid` goes to the correct master.
- Locked burst, `MAX_LOCK`=4: m1 write burst with lock held while m0 requests a load:
  - m1 granted for 4 cycles, then m0 granted once, then m1 resumes.
  - `cpu_stall`=1 for exactly 4 cycles.
- Lock release: m1 drops `m1_lock` mid-burst with both still requesting -> next contention cycle grants m0 and `lock_cnt` returns to 0.
- Reset mid-read: assert `rst` in the cycle after an m1 load grant -> `m1_rvalid` never asserts, and the first contention after release grants m0.
